// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative 32x32 signed/unsigned multiply and divide.
// Produces one result bit per clock using a shift-add multiplier or a
// restoring divider that share a 2*WIDTH-bit accumulator. A start/busy/done
// handshake lets the datapath stall while the unit is busy. Signed operations
// run on operand magnitudes, and the sign is corrected in a final FIX cycle.
module mult_div_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] operand_a,
   input  logic [WIDTH-1:0] operand_b,
   output logic             busy,
   output logic             done,
   output logic             div_by_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CW = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      CALC = 2'b01,
      FIX  = 2'b10
   } state_t;

   // Two's-complement negate of a WIDTH-bit value when en is set.
   function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic en);
      logic [WIDTH-1:0] r;
      if (en) begin
         r = ~v + {{(WIDTH-1){1'b0}}, 1'b1};
      end else begin
         r = v;
      end
      return r;
   endfunction

   // Two's-complement negate of a double-width product when en is set.
   function automatic logic [2*WIDTH-1:0] cond_neg2(input logic [2*WIDTH-1:0] v, input logic en);
      logic [2*WIDTH-1:0] r;
      if (en) begin
         r = ~v + {{(2*WIDTH-1){1'b0}}, 1'b1};
      end else begin
         r = v;
      end
      return r;
   endfunction

   state_t             state_r, state_s;
   logic [CW-1:0]      cnt_r, cnt_s;
   logic               is_div_r, is_div_s;
   logic               neg_lo_r, neg_lo_s;   // negate product / quotient
   logic               neg_hi_r, neg_hi_s;   // negate remainder
   logic               dbz_r, dbz_s;         // divisor was zero on accept
   logic [WIDTH-1:0]   acc_hi_r, acc_hi_s;   // product high / partial remainder
   logic [WIDTH-1:0]   acc_lo_r, acc_lo_s;   // multiplier / dividend->quotient
   logic [WIDTH-1:0]   opd_r, opd_s;         // multiplicand or divisor magnitude
   logic               busy_r, busy_s;
   logic               done_r, done_s;
   logic               dbz_out_r, dbz_out_s;
   logic [WIDTH-1:0]   hi_r, hi_s;
   logic [WIDTH-1:0]   lo_r, lo_s;

   logic               signed_op_s;
   logic [WIDTH-1:0]   a_mag_s, b_mag_s;
   logic [WIDTH:0]     msum_s;               // shift-add partial sum with carry
   logic [WIDTH:0]     rsh_s;                // remainder shifted with next dividend bit
   logic [WIDTH:0]     rdiff_s;              // trial subtraction, MSB set means borrow
   logic [2*WIDTH-1:0] prod_s;

   assign busy        = busy_r;
   assign done        = done_r;
   assign div_by_zero = dbz_out_r;
   assign hi          = hi_r;
   assign lo          = lo_r;

   // FSM state register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Next-state, iteration datapath and result formation.
   always_comb begin
      state_s     = state_r;
      cnt_s       = cnt_r;
      is_div_s    = is_div_r;
      neg_lo_s    = neg_lo_r;
      neg_hi_s    = neg_hi_r;
      dbz_s       = dbz_r;
      acc_hi_s    = acc_hi_r;
      acc_lo_s    = acc_lo_r;
      opd_s       = opd_r;
      busy_s      = busy_r;
      done_s      = 1'b0;
      dbz_out_s   = dbz_out_r;
      hi_s        = hi_r;
      lo_s        = lo_r;

      signed_op_s = ~op[0];
      a_mag_s     = cond_neg(operand_a, signed_op_s & operand_a[WIDTH-1]);
      b_mag_s     = cond_neg(operand_b, signed_op_s & operand_b[WIDTH-1]);
      msum_s      = {1'b0, acc_hi_r} + {1'b0, opd_r};
      rsh_s       = {acc_hi_r, acc_lo_r[WIDTH-1]};
      rdiff_s     = rsh_s - {1'b0, opd_r};
      prod_s      = cond_neg2({acc_hi_r, acc_lo_r}, neg_lo_r);

      case (state_r)
         IDLE: begin
            if (start) begin
               is_div_s = op[1];
               neg_lo_s = signed_op_s & (operand_a[WIDTH-1] ^ operand_b[WIDTH-1]);
               neg_hi_s = signed_op_s & op[1] & operand_a[WIDTH-1];
               busy_s   = 1'b1;
               cnt_s    = {CW{1'b0}};
               acc_hi_s = {WIDTH{1'b0}};
               if (op[1]) begin
                  acc_lo_s = a_mag_s;
                  opd_s    = b_mag_s;
               end else begin
                  acc_lo_s = b_mag_s;
                  opd_s    = a_mag_s;
               end
               if (op[1] && (operand_b == {WIDTH{1'b0}})) begin
                  dbz_s    = 1'b1;
                  acc_hi_s = operand_a;
                  state_s  = FIX;
               end else begin
                  dbz_s    = 1'b0;
                  state_s  = CALC;
               end
            end else begin
               state_s = IDLE;
            end
         end
         CALC: begin
            if (is_div_r) begin
               if (!rdiff_s[WIDTH]) begin
                  acc_hi_s = rdiff_s[WIDTH-1:0];
                  acc_lo_s = {acc_lo_r[WIDTH-2:0], 1'b1};
               end else begin
                  acc_hi_s = rsh_s[WIDTH-1:0];
                  acc_lo_s = {acc_lo_r[WIDTH-2:0], 1'b0};
               end
            end else begin
               if (acc_lo_r[0]) begin
                  {acc_hi_s, acc_lo_s} = {msum_s, acc_lo_r[WIDTH-1:1]};
               end else begin
                  {acc_hi_s, acc_lo_s} = {1'b0, acc_hi_r, acc_lo_r[WIDTH-1:1]};
               end
            end
            cnt_s = cnt_r + {{(CW-1){1'b0}}, 1'b1};
            if (cnt_r == CW'(WIDTH-1)) begin
               state_s = FIX;
            end else begin
               state_s = CALC;
            end
         end
         FIX: begin
            done_s  = 1'b1;
            busy_s  = 1'b0;
            state_s = IDLE;
            if (dbz_r) begin
               hi_s      = acc_hi_r;
               lo_s      = {WIDTH{1'b1}};
               dbz_out_s = 1'b1;
            end else if (is_div_r) begin
               hi_s      = cond_neg(acc_hi_r, neg_hi_r);
               lo_s      = cond_neg(acc_lo_r, neg_lo_r);
               dbz_out_s = 1'b0;
            end else begin
               hi_s      = prod_s[2*WIDTH-1:WIDTH];
               lo_s      = prod_s[WIDTH-1:0];
               dbz_out_s = 1'b0;
            end
         end
         default: begin
            state_s = IDLE;
            busy_s  = 1'b0;
         end
      endcase
   end

   // Datapath and output registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_r     <= {CW{1'b0}};
         is_div_r  <= 1'b0;
         neg_lo_r  <= 1'b0;
         neg_hi_r  <= 1'b0;
         dbz_r     <= 1'b0;
         acc_hi_r  <= {WIDTH{1'b0}};
         acc_lo_r  <= {WIDTH{1'b0}};
         opd_r     <= {WIDTH{1'b0}};
         busy_r    <= 1'b0;
         done_r    <= 1'b0;
         dbz_out_r <= 1'b0;
         hi_r      <= {WIDTH{1'b0}};
         lo_r      <= {WIDTH{1'b0}};
      end else begin
         cnt_r     <= cnt_s;
         is_div_r  <= is_div_s;
         neg_lo_r  <= neg_lo_s;
         neg_hi_r  <= neg_hi_s;
         dbz_r     <= dbz_s;
         acc_hi_r  <= acc_hi_s;
         acc_lo_r  <= acc_lo_s;
         opd_r     <= opd_s;
         busy_r    <= busy_s;
         done_r    <= done_s;
         dbz_out_r <= dbz_out_s;
         hi_r      <= hi_s;
         lo_r      <= lo_s;
      end
   end

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: the driver pushes reference results
// computed with 64-bit integer arithmetic, and the monitor pops and compares
// them whenever done is seen, including the exact completion cycle.
module tb_mult_div_unit;
   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         start = 1'b0;
   logic [1:0]   op = 2'b00;
   logic [W-1:0] operand_a = '0;
   logic [W-1:0] operand_b = '0;
   logic         busy, done, div_by_zero;
   logic [W-1:0] hi, lo;

   mult_div_unit #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .start(start), .op(op),
      .operand_a(operand_a), .operand_b(operand_b),
      .busy(busy), .done(done), .div_by_zero(div_by_zero),
      .hi(hi), .lo(lo)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]   op;
      logic [W-1:0] hi;
      logic [W-1:0] lo;
      logic         dbz;
      int           acc;
      int           due;
   } exp_t;

   exp_t sbq[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;

   // Count rising edges; after edge k, cyc == k.
   always @(posedge clk) cyc <= cyc + 1;

   // Reference model: plain 64-bit arithmetic (SV division truncates toward zero,
   // and % takes the sign of the dividend).
   function automatic exp_t model(input logic [1:0] o, input logic [W-1:0] a,
                                  input logic [W-1:0] b, input int acc);
      exp_t e;
      longint sa, sb, q64, r64;
      longint unsigned ua, ub, uq, ur;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = {32'd0, a};
      ub = {32'd0, b};
      e.op = o; e.dbz = 1'b0; e.acc = acc; e.due = acc + W + 1;
      e.hi = '0; e.lo = '0;
      if (o[1] && b == 0) begin
         e.hi = a; e.lo = {W{1'b1}}; e.dbz = 1'b1; e.due = acc + 1;
      end else begin
         case (o)
            2'b00: begin q64 = sa * sb; e.hi = q64[63:32]; e.lo = q64[31:0]; end
            2'b01: begin uq = ua * ub;  e.hi = uq[63:32];  e.lo = uq[31:0];  end
            2'b10: begin q64 = sa / sb; r64 = sa % sb; e.lo = q64[31:0]; e.hi = r64[31:0]; end
            default: begin uq = ua / ub; ur = ua % ub; e.lo = uq[31:0]; e.hi = ur[31:0]; end
         endcase
      end
      return e;
   endfunction

   // Called at a falling edge: waits for busy=0 (bounded), then presents one request.
   task automatic issue(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
      int n = 0;
      while (busy && n < 100) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (busy) begin
         errors++;
         $display("FAIL issue_wait: busy=%b after %0d cycles, required 0", busy, n);
      end else begin
         start = 1'b1; op = o; operand_a = a; operand_b = b;
         sbq.push_back(model(o, a, b, cyc + 1));
         @(negedge clk);
         start = 1'b0;
      end
   endtask

   function automatic logic [W-1:0] pick(input int sel);
      logic [W-1:0] v;
      case (sel)
         0: v = '0;
         1: v = {W{1'b1}};
         2: v = 32'h8000_0000;
         3: v = 32'h7FFF_FFFF;
         4: v = 32'($urandom_range(0, 20));
         default: v = $urandom;
      endcase
      return v;
   endfunction

   // Monitor: checks reset values, busy while pending, and each result on done.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (!rst) begin
            checks++;
            if (busy !== 1'b0 || done !== 1'b0 || div_by_zero !== 1'b0 || hi !== '0 || lo !== '0) begin
               errors++;
               $display("FAIL reset_state: busy=%b done=%b dbz=%b hi=%h lo=%h, required all 0",
                        busy, done, div_by_zero, hi, lo);
            end
         end else if (done === 1'b1) begin
            checks++;
            if (sbq.size() == 0) begin
               errors++;
               $display("FAIL unexpected_done: done=1 at cycle %0d with nothing outstanding", cyc);
            end else begin
               e = sbq.pop_front();
               if (hi !== e.hi || lo !== e.lo || div_by_zero !== e.dbz || cyc != e.due || busy !== 1'b0) begin
                  errors++;
                  $display("FAIL result op%0d: hi=%h lo=%h dbz=%b busy=%b cyc=%0d, required hi=%h lo=%h dbz=%b busy=0 cyc=%0d",
                           e.op, hi, lo, div_by_zero, busy, cyc, e.hi, e.lo, e.dbz, e.due);
               end
            end
         end else if (sbq.size() > 0 && cyc >= sbq[0].acc) begin
            checks++;
            if (cyc > sbq[0].due) begin
               errors++;
               $display("FAIL late_done op%0d: no done by cycle %0d, required at %0d", sbq[0].op, cyc, sbq[0].due);
               void'(sbq.pop_front());
            end else if (busy !== 1'b1) begin
               errors++;
               $display("FAIL busy_pending op%0d: busy=%b at cycle %0d, required 1", sbq[0].op, busy, cyc);
            end
         end
      end
   end

   // Driver: directed cases, mid-operation reset, then randomized traffic.
   initial begin
      int n;
      rst = 1'b0;
      repeat (3) @(negedge clk);
      #3 rst = 1'b1;
      @(negedge clk);

      issue(2'b00, 32'd7, 32'hFFFF_FFFD);
      issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      issue(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      issue(2'b10, 32'hFFFF_FFF9, 32'd2);
      issue(2'b11, 32'd100, 32'd7);
      issue(2'b10, 32'd5, 32'd0);
      issue(2'b11, 32'd9, 32'd3);
      issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
      // Inputs churn while busy; none of this may be accepted.
      for (int i = 0; i < 20; i++) begin
         start = 1'($urandom_range(0, 1));
         op = 2'($urandom_range(0, 3));
         operand_a = $urandom;
         operand_b = $urandom;
         @(negedge clk);
      end
      start = 1'b0;

      // Reset in the middle of a calculation discards it.
      issue(2'b01, $urandom, $urandom);
      repeat (9) @(negedge clk);
      #3 rst = 1'b0;
      sbq.delete();
      @(negedge clk);
      #3 rst = 1'b1;
      @(negedge clk);
      issue(2'b01, 32'd3, 32'd4);
      issue(2'b11, $urandom, 32'($urandom_range(1, 1000)));

      for (int i = 0; i < 150; i++) begin
         issue(2'($urandom_range(0, 3)), pick($urandom_range(0, 7)), pick($urandom_range(0, 7)));
      end

      n = 0;
      while (sbq.size() > 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (sbq.size() > 0) begin
         errors++;
         $display("FAIL drain: %0d results outstanding, required 0", sbq.size());
      end
      repeat (3) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
